// File: rtl/hc800_ram_pkg.sv
// Shared definitions for the HC800 RAM path: arbiter FSM states and default
// SDRAM port geometry / timing.
package hc800_ram_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arb_state_e;

    localparam int unsigned RAM_ADDR_WIDTH      = 21;
    localparam int unsigned RAM_DATA_WIDTH      = 8;
    localparam int unsigned RAM_DEFAULT_LATENCY = 2;

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the byte-wide SDRAM controller port between the CPU RAM
// bus (port A) and a DMA requester (port B). One access is in flight at a time;
// the controller's fixed read latency is waited out before the requester is
// acknowledged. Port B is guaranteed a grant after STARVE_LIMIT consecutive A
// grants made while B was pending.
//
// Ports:
//   bus_clk, bus_reset        bus clock, synchronous active-high reset
//   a_req/a_write/a_address/a_wdata -> a_ack/a_rdata   port A (CPU)
//   b_req/b_write/b_address/b_wdata -> b_ack/b_rdata   port B (DMA)
//   mem_enable/mem_write/mem_address/mem_wdata, mem_rdata   controller side
//   busy                      high whenever an access is in progress
module ram_arbiter
    import hc800_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = RAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = RAM_DATA_WIDTH,
    parameter int unsigned LATENCY      = RAM_DEFAULT_LATENCY,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  bus_clk,
    input  logic                  bus_reset,

    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  mem_enable,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    localparam logic [3:0] LatLoad   = 4'(LATENCY - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic                  gnt_b_q, gnt_b_d;   // 1: current access belongs to port B
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            lat_q, lat_d;
    logic [3:0]            starve_q, starve_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

    // B wins only when A is idle or A has used up its run of grants.
    function automatic logic pick_b(input logic req_a, input logic req_b,
                                    input logic [3:0] starve);
        return req_b && (!req_a || (starve == StarveMax));
    endfunction

    logic win_b;
    assign win_b = pick_b(a_req, b_req, starve_q);

    always_comb begin
        state_d   = state_q;
        gnt_b_d   = gnt_b_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_d     = lat_q;
        starve_d  = starve_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (!b_req) begin
                    starve_d = '0;
                end
                if (a_req || b_req) begin
                    state_d = StIssue;
                    if (win_b) begin
                        gnt_b_d  = 1'b1;
                        wr_d     = b_write;
                        addr_d   = b_address;
                        wdata_d  = b_wdata;
                        starve_d = '0;
                    end else begin
                        gnt_b_d = 1'b0;
                        wr_d    = a_write;
                        addr_d  = a_address;
                        wdata_d = a_wdata;
                        if (b_req && (starve_q != StarveMax)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            StIssue: begin
                lat_d   = LatLoad;
                state_d = (LATENCY == 1) ? StDone : StWait;
            end
            StWait: begin
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (gnt_b_q) begin
                    b_rdata_d = mem_rdata;
                end else begin
                    a_rdata_d = mem_rdata;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_reset) begin
            state_q   <= StIdle;
            gnt_b_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_q     <= '0;
            starve_q  <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_b_q   <= gnt_b_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_q     <= lat_d;
            starve_q  <= starve_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // All outputs decode directly from registered state, so they are glitch-free
    // and inactive outside their owning state.
    assign mem_enable  = (state_q == StIssue);
    assign mem_write   = mem_enable & wr_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = (state_q != StIdle);

    assign a_ack = (state_q == StDone) && !gnt_b_q;
    assign b_ack = (state_q == StDone) &&  gnt_b_q;

    // Data is captured in DONE; pass it straight through during the ack cycle
    // so it is valid alongside the pulse.
    assign a_rdata = a_ack ? mem_rdata : a_rdata_q;
    assign b_rdata = b_ack ? mem_rdata : b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        bus_reset;
    logic        a_req, a_write, b_req, b_write;
    logic [20:0] a_address, b_address;
    logic [7:0]  a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [7:0]  a_rdata, b_rdata;
    logic        mem_enable, mem_write, busy;
    logic [20:0] mem_address;
    logic [7:0]  mem_wdata, mem_rdata;

    ram_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(4)) dut (
        .bus_clk(clk), .bus_reset(bus_reset),
        .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Latency-variant instances: port A only, fixed controller data.
    logic        req_l1, req_l15, ack_l1, ack_l15, bk_l1, bk_l15;
    logic [7:0]  rd_l1, rd_l15, brd_l1, brd_l15, mwd_l1, mwd_l15;
    logic        me_l1, me_l15, mw_l1, mw_l15, busy_l1, busy_l15;
    logic [20:0] ma_l1, ma_l15;
    logic [20:0] lat_addr  = 21'h000042;
    logic [7:0]  lat_data  = 8'h3C;
    logic        zero_bit  = 1'b0;
    logic [7:0]  zero_byte = 8'h00;
    logic [20:0] zero_addr = 21'h0;

    ram_arbiter #(.LATENCY(1), .STARVE_LIMIT(4)) dut_l1 (
        .bus_clk(clk), .bus_reset(bus_reset),
        .a_req(req_l1), .a_write(zero_bit), .a_address(lat_addr), .a_wdata(zero_byte),
        .a_ack(ack_l1), .a_rdata(rd_l1),
        .b_req(zero_bit), .b_write(zero_bit), .b_address(zero_addr), .b_wdata(zero_byte),
        .b_ack(bk_l1), .b_rdata(brd_l1),
        .mem_enable(me_l1), .mem_write(mw_l1), .mem_address(ma_l1),
        .mem_wdata(mwd_l1), .mem_rdata(lat_data), .busy(busy_l1)
    );

    ram_arbiter #(.LATENCY(15), .STARVE_LIMIT(4)) dut_l15 (
        .bus_clk(clk), .bus_reset(bus_reset),
        .a_req(req_l15), .a_write(zero_bit), .a_address(lat_addr), .a_wdata(zero_byte),
        .a_ack(ack_l15), .a_rdata(rd_l15),
        .b_req(zero_bit), .b_write(zero_bit), .b_address(zero_addr), .b_wdata(zero_byte),
        .b_ack(bk_l15), .b_rdata(brd_l15),
        .mem_enable(me_l15), .mem_write(mw_l15), .mem_address(ma_l15),
        .mem_wdata(mwd_l15), .mem_rdata(lat_data), .busy(busy_l15)
    );

    // SDRAM model: byte array, writes land at the strobe, read data appears
    // exactly LAT cycles after the strobe cycle.
    bit [7:0]       sdram [0:(1<<21)-1];
    bit [15:0][7:0] pipe;
    always @(posedge clk) begin
        if (mem_enable && mem_write) sdram[mem_address] <= mem_wdata;
        pipe <= {pipe[14:0], (mem_enable && !mem_write) ? sdram[mem_address] : 8'hEE};
    end
    assign mem_rdata = pipe[LAT-1];

    // Transaction-level reference: memory contents as seen in ack order.
    bit [7:0] ref_mem [int];
    function automatic bit [7:0] ref_rd(input logic [20:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    int n_cmp = 0;
    int n_fail = 0;

    bit mon_en = 1'b0;
    int a_acks, b_acks;
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_ack) a_acks++;
            if (b_ack) b_acks++;
            n_cmp++;
            if (a_ack && b_ack) begin
                n_fail++;
                $display("FAIL dual_ack: a_ack=%b b_ack=%b, required not both", a_ack, b_ack);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        bus_reset = 1'b1;
        a_req = 0; b_req = 0; req_l1 = 0; req_l15 = 0;
        repeat (2) @(negedge clk);
        bus_reset = 1'b0;
    endtask

    task automatic test_reset();
        bus_reset = 1'b1;
        a_req = 0; b_req = 0; a_write = 0; b_write = 0; req_l1 = 0; req_l15 = 0;
        a_address = 0; b_address = 0; a_wdata = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_enable, mem_write, a_ack, b_ack, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {mem_enable, mem_write, a_ack, b_ack, busy});
        end
        n_cmp++;
        if ({mem_address, mem_wdata, a_rdata, b_rdata} !== 45'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0",
                     {mem_address, mem_wdata, a_rdata, b_rdata});
        end
        bus_reset = 1'b0;
    endtask

    task automatic test_port_a_read();
        logic [20:0] addr = 21'h0ABCDE;
        a_address = addr; a_wdata = 8'h5A; a_write = 1; a_req = 1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (a_ack !== 1'b1) begin
            n_fail++; $display("FAIL a_write_ack: got %b required 1", a_ack);
        end
        ref_mem[int'(addr)] = 8'h5A;
        a_req = 0;
        @(negedge clk);
        a_write = 0; a_req = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (b_ack !== 1'b0) begin
                n_fail++; $display("FAIL a_read_bnoack: cycle %0d b_ack=%b required 0", k, b_ack);
            end
            n_cmp++;
            if (k == 1 && {mem_enable, mem_write, mem_address, a_ack} !== {2'b10, addr, 1'b0}) begin
                n_fail++;
                $display("FAIL a_read_issue: got en=%b we=%b addr=%h ack=%b required 1 0 %h 0",
                         mem_enable, mem_write, mem_address, a_ack, addr);
            end else if (k == 2 && {mem_enable, busy, a_ack} !== 3'b010) begin
                n_fail++;
                $display("FAIL a_read_wait: got en/busy/ack=%b required 010",
                         {mem_enable, busy, a_ack});
            end else if (k == 3 && {a_ack, a_rdata} !== {1'b1, 8'h5A}) begin
                n_fail++;
                $display("FAIL a_read_done: got ack=%b rdata=%h required 1 5a", a_ack, a_rdata);
            end
        end
        a_req = 0;
        @(negedge clk);
        n_cmp++;
        if ({a_ack, busy, a_rdata} !== {2'b00, 8'h5A}) begin
            n_fail++;
            $display("FAIL a_read_hold: got ack=%b busy=%b rdata=%h required 0 0 5a",
                     a_ack, busy, a_rdata);
        end
    endtask

    task automatic test_port_b_write();
        b_address = 21'h1FFFFF; b_wdata = 8'hC3; b_write = 1; b_req = 1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k == 1 && {mem_enable, mem_write, mem_address, mem_wdata}
                          !== {2'b11, 21'h1FFFFF, 8'hC3}) begin
                n_fail++;
                $display("FAIL b_write_issue: got en=%b we=%b addr=%h wd=%h required 1 1 1fffff c3",
                         mem_enable, mem_write, mem_address, mem_wdata);
            end else if (k == 2 && {mem_enable, mem_write, b_ack} !== 3'b000) begin
                n_fail++;
                $display("FAIL b_write_pulse: got en/we/ack=%b required 000",
                         {mem_enable, mem_write, b_ack});
            end else if (k == 3 && {b_ack, a_ack} !== 2'b10) begin
                n_fail++;
                $display("FAIL b_write_ack: got b_ack=%b a_ack=%b required 1 0", b_ack, a_ack);
            end
        end
        b_req = 0; b_write = 0;
        ref_mem[int'(21'h1FFFFF)] = 8'hC3;
        @(negedge clk);
        n_cmp++;
        if (sdram[21'h1FFFFF] !== 8'hC3) begin
            n_fail++;
            $display("FAIL b_write_mem: got %h required c3", sdram[21'h1FFFFF]);
        end
    endtask

    task automatic test_starvation();
        int  got = 0;
        bit  exp_b;
        do_reset();
        a_address = 21'h000200; b_address = 21'h000300;
        a_write = 0; b_write = 0; a_req = 1; b_req = 1;
        for (int t = 0; t < 200 && got < 15; t++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                exp_b = (got % 5 == 4);
                n_cmp++;
                if (b_ack !== exp_b || a_ack !== !exp_b) begin
                    n_fail++;
                    $display("FAIL starve_order: grant %0d got a=%b b=%b required b=%b",
                             got, a_ack, b_ack, exp_b);
                end
                got++;
            end
        end
        a_req = 0; b_req = 0;
        n_cmp++;
        if (got != 15) begin
            n_fail++; $display("FAIL starve_timeout: got %0d grants required 15", got);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        a_address = 21'h000123; a_write = 0; a_req = 1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, mem_enable} !== 2'b10) begin
            n_fail++; $display("FAIL rst_mid_wait: got busy/en=%b required 10", {busy, mem_enable});
        end
        bus_reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_ack, b_ack, busy, mem_enable, mem_address, a_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL rst_mid_idle: ack=%b%b busy=%b en=%b addr=%h rdata=%h required all 0",
                     a_ack, b_ack, busy, mem_enable, mem_address, a_rdata);
        end
        bus_reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({mem_enable, a_ack} !== {k == 1, k == 3}) begin
                n_fail++;
                $display("FAIL rst_mid_regrant: cycle %0d got en=%b ack=%b required %b %b",
                         k, mem_enable, a_ack, k == 1, k == 3);
            end
        end
        a_req = 0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        req_l1 = 1; req_l15 = 1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ack_l1 !== (k == 2)) begin
                n_fail++; $display("FAIL lat1_ack: cycle %0d got %b required %b", k, ack_l1, k == 2);
            end
            n_cmp++;
            if (ack_l15 !== (k == 16)) begin
                n_fail++;
                $display("FAIL lat15_ack: cycle %0d got %b required %b", k, ack_l15, k == 16);
            end
            if (ack_l1) begin
                n_cmp++;
                if (rd_l1 !== 8'h3C) begin
                    n_fail++; $display("FAIL lat1_data: got %h required 3c", rd_l1);
                end
                req_l1 = 0;
            end
            if (ack_l15) begin
                n_cmp++;
                if (rd_l15 !== 8'h3C) begin
                    n_fail++; $display("FAIL lat15_data: got %h required 3c", rd_l15);
                end
                req_l15 = 0;
            end
        end
        req_l1 = 0; req_l15 = 0;
    endtask

    task automatic run_port(input bit is_b, input int n, output int issued);
        logic [20:0] addr;
        logic [7:0]  data, got;
        bit          wr, acked;
        int          idx;
        issued = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            idx  = $urandom_range(0, 8);
            addr = (idx == 8) ? 21'h1FFFFF : 21'h000100 + 21'(idx);
            wr   = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            if (is_b) begin
                b_address = addr; b_write = wr; b_wdata = data; b_req = 1;
            end else begin
                a_address = addr; a_write = wr; a_wdata = data; a_req = 1;
            end
            issued++;
            acked = 0;
            for (int t = 0; t < 100 && !acked; t++) begin
                @(negedge clk);
                acked = is_b ? b_ack : a_ack;
            end
            got = is_b ? b_rdata : a_rdata;
            if (is_b) b_req = 0; else a_req = 0;
            n_cmp++;
            if (!acked) begin
                n_fail++; $display("FAIL rand_timeout: port %s txn %0d no ack", is_b ? "B" : "A", i);
            end else if (wr) begin
                ref_mem[int'(addr)] = data;
            end else if (got !== ref_rd(addr)) begin
                n_fail++;
                $display("FAIL rand_read: port %s addr %h got %h required %h",
                         is_b ? "B" : "A", addr, got, ref_rd(addr));
            end
        end
    endtask

    task automatic test_random();
        int na, nb;
        @(negedge clk);
        a_acks = 0; b_acks = 0; mon_en = 1'b1;
        fork
            run_port(1'b0, 30, na);
            run_port(1'b1, 30, nb);
        join
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        n_cmp++;
        if (a_acks != na || b_acks != nb) begin
            n_fail++;
            $display("FAIL rand_ack_count: got A=%0d B=%0d required A=%0d B=%0d",
                     a_acks, b_acks, na, nb);
        end
    endtask

    initial begin
        test_reset();
        test_port_a_read();
        test_port_b_write();
        test_starvation();
        test_reset_mid();
        test_latency();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single byte-wide SDRAM controller port between the HC800 CPU RAM bus (port A) and a DMA requester (port B, e.g. SD-image/loader transfers). It sits in the `bus_clk` (13.5 MHz) domain between the requesters and the `sdram` controller's cpu interface. It serialises accesses, enforces the controller's fixed read latency, and guarantees port B forward progress against a busy CPU.

## Interface
- `ADDR_WIDTH`, 21, byte address width (2 MiB window).
- `DATA_WIDTH`, 8, data width.
- `LATENCY`, 2, `bus_clk` cycles from `mem_enable` to valid `mem_rdata`; range 1..15.
- `STARVE_LIMIT`, 4, consecutive port A grants allowed while B is pending; range 1..15.
- `bus_clk`  in  1  system bus clock.
- `bus_reset`  in  1  synchronous, active-high reset.
- `a_req`  in  1  port A request, held until `a_ack`.
- `a_write`  in  1  port A write (1) / read (0).
- `a_address`  in  ADDR_WIDTH  port A byte address.
- `a_wdata`  in  DATA_WIDTH  port A write data.
- `a_ack`  out  1  one-cycle completion pulse.
- `a_rdata`  out  DATA_WIDTH  read data, valid while `a_ack`=1.
- `b_req`, `b_write`, `b_address`, `b_wdata`, `b_ack`, `b_rdata`: same as port A, for port B.
- `mem_enable`  out  1  access strobe to controller (`oe`).
- `mem_write`  out  1  write qualifier (`we` = `mem_write` & `mem_enable`).
- `mem_address`  out  ADDR_WIDTH  to controller `addr`.
- `mem_wdata`  out  DATA_WIDTH  to controller `din` (duplicated onto both bytes by the parent).
- `mem_rdata`  in  DATA_WIDTH  controller `dout` low byte.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample `a_req`/`b_req`. If either is set, latch the winner's write, address and wdata into registers and go to ISSUE.
  - The winner is A unless B is pending and `starve_cnt` == `STARVE_LIMIT`. In that case B wins.
  - If only one port requests, that port wins.
- ISSUE: drive `mem_enable`=1 with the latched `mem_write`, `mem_address` and `mem_wdata` for exactly one cycle. Load the latency counter with `LATENCY`-1. Go to WAIT, or go straight to DONE when `LATENCY`=1.
- WAIT: decrement the counter. When it reaches 0, go to DONE.
- DONE:
  - Capture `mem_rdata` into the granted port's rdata register.
  - Pulse the granted port's ack for one cycle, then return to IDLE.
  - Writes also ack here, so a write's ack latency equals a read's.
- `starve_cnt` (4 bits):
  - Increments on each A grant made while `b_req`=1.
  - Clears on a B grant, and clears when `b_req`=0 in IDLE.
  - Saturates at `STARVE_LIMIT`.
- Outputs are inactive outside ISSUE: `mem_enable`=0, `mem_write`=0. `mem_address` and `mem_wdata` hold their last latched value.
- `a_rdata`/`b_rdata` hold their last captured value between acks. Only the granted port's register updates.
- Requester rule: a requester that keeps `req` high in the cycle after its ack starts a new transaction. The arbiter does not distinguish this from a stale request. Request inputs are ignored outside IDLE.
- Reset:
  - `bus_reset`=1 at any clock edge forces IDLE and clears `starve_cnt`.
  - Reset drives `mem_enable`, `mem_write`, `a_ack`, `b_ack` and `busy` to 0, and clears `mem_address`, `mem_wdata`, `a_rdata` and `b_rdata` to 0.
  - Reset mid-transaction abandons the transaction with no ack. The controller's own `init` handles in-flight SDRAM state.

## Timing
- Cycle 0 (IDLE, req sampled) → cycle 1 ISSUE → cycles 2..LATENCY WAIT → cycle LATENCY+1 DONE, with ack and rdata valid.
- Request-to-ack latency is `LATENCY`+1 cycles (3 at default).
- Back-to-back throughput is one access per `LATENCY`+2 cycles (4 at default), because DONE is followed by one IDLE cycle.
- `mem_rdata` is sampled in the DONE cycle, which is exactly `LATENCY` cycles after `mem_enable` was high.
- Simultaneous `a_req` and `b_req` with `starve_cnt` < `STARVE_LIMIT`: A wins, B stays pending, and `starve_cnt` increments.
- `busy` is registered and goes high the cycle after the grant decision (the ISSUE cycle).

## Structure
- Shared package `hc800_ram_pkg`:
  - FSM state enum.
  - `RAM_ADDR_WIDTH`=21, `RAM_DATA_WIDTH`=8.
  - `RAM_DEFAULT_LATENCY`=2.
- A single flat module. Winner select is an inline function, so no sub-module is needed.

## Test plan
- Port A read only, `LATENCY`=2, model returns 0x5A: `a_req` at cycle 0 → `mem_enable` in cycle 1 with the address; `a_ack`=1 and `a_rdata`=0x5A in cycle 3; `b_ack` never asserts.
- Port B write of 0xC3 to 0x1FFFFF → `mem_write`=1, `mem_address`=0x1FFFFF and `mem_wdata`=0xC3 for exactly one cycle; `b_ack` 2 cycles later.
- Both ports requesting continuously, `STARVE_LIMIT`=4 → grant order A,A,A,A,B repeating; B is never starved beyond 5 grants.
- `bus_reset` asserted during WAIT → next cycle state is IDLE, all acks 0, and `mem_enable` stays 0; after release, a pending `a_req` is granted normally.
- `LATENCY`=1 build → ISSUE goes directly to DONE and ack arrives 2 cycles after the request; `LATENCY`=15 → ack arrives at 16 cycles.
- Random traffic on both ports against a byte-array SDRAM model → every read returns the last written value, with exactly one ack per request.
